// File: rtl/manager_pkg.sv
// Shared types and address-map helpers for the manager loader.
package manager_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD_W,
    ST_LOAD_I,
    ST_START,
    ST_WAIT_DONE,
    ST_READ_O,
    ST_EMIT
  } loader_state_t;

  function automatic int unsigned addr_w_base();
    return 0;
  endfunction

  function automatic int unsigned addr_i_base(input int unsigned li, input int unsigned lm,
                                              input int unsigned lo);
    return li * lm + lm * lo;
  endfunction

  function automatic int unsigned addr_start(input int unsigned li, input int unsigned lm,
                                             input int unsigned lo);
    return addr_i_base(li, lm, lo) + li;
  endfunction

  function automatic int unsigned addr_o_base(input int unsigned li, input int unsigned lm,
                                              input int unsigned lo);
    return addr_start(li, lm, lo) + 1;
  endfunction

endpackage

// File: rtl/manager_bus_port.sv
// Single-access bus engine: launches one read or write, holds it until bus_ready,
// then returns ack with a mandatory idle cycle before the next access.
module manager_bus_port #(
  parameter int unsigned WIDTH      = 4,
  parameter int unsigned WIDTH_W    = 9,
  parameter int unsigned WIDTH_ADDR = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req,
  input  logic                  rnw,
  input  logic                  abort,
  input  logic [WIDTH_ADDR-1:0] addr,
  input  logic [WIDTH_W-1:0]    wdata,
  output logic [WIDTH_W-1:0]    bus_wdata,
  output logic [WIDTH_ADDR-1:0] bus_addr,
  output logic                  bus_read,
  output logic                  bus_write,
  input  logic [WIDTH-1:0]      bus_rdata,
  input  logic                  bus_ready,
  output logic                  ack,
  output logic [WIDTH-1:0]      rdata_q
);

  logic active;
  assign active = bus_read | bus_write;

  // ack doubles as the idle-gap cycle: no new access may start while it is high
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus_wdata <= '0;
      bus_addr  <= '0;
      bus_read  <= 1'b0;
      bus_write <= 1'b0;
      ack       <= 1'b0;
      rdata_q   <= '0;
    end else begin
      ack <= 1'b0;
      if (abort) begin
        bus_read  <= 1'b0;
        bus_write <= 1'b0;
      end else if (active) begin
        if (bus_ready) begin
          bus_read  <= 1'b0;
          bus_write <= 1'b0;
          ack       <= 1'b1;
          if (bus_read) rdata_q <= bus_rdata;
        end
      end else if (req && !ack) begin
        bus_addr  <= addr;
        bus_wdata <= rnw ? '0 : wdata;
        bus_read  <= rnw;
        bus_write <= !rnw;
      end
    end
  end

endmodule

// File: rtl/manager_loader.sv
// Loads weights/inputs into `manager`, issues START, waits for down and streams results.
// Optional bus/compute timeout with sticky err: define MANAGER_LOADER_TIMEOUT_EN.
module manager_loader
  import manager_pkg::*;
#(
  parameter int unsigned WIDTH      = 4,
  parameter int unsigned WIDTH_W    = 9,
  parameter int unsigned LENGHT_I   = 2,
  parameter int unsigned LENGHT_MID = 2,
  parameter int unsigned LENGHT_O   = 2,
  parameter int unsigned N_W        = LENGHT_I * LENGHT_MID + LENGHT_MID * LENGHT_O,
  parameter int unsigned WIDTH_ADDR = $clog2(N_W + LENGHT_I + LENGHT_O + 3)
`ifdef MANAGER_LOADER_TIMEOUT_EN
  , parameter int unsigned TIMEOUT  = 255
`endif
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  s_valid,
  input  logic [WIDTH_W-1:0]    s_data,
  output logic                  s_ready,
  output logic [WIDTH_W-1:0]    bus_wdata,
  output logic [WIDTH_ADDR-1:0] bus_addr,
  output logic                  bus_read,
  output logic                  bus_write,
  input  logic [WIDTH-1:0]      bus_rdata,
  input  logic                  bus_ready,
  input  logic                  bus_down,
  output logic                  r_valid,
  output logic [WIDTH-1:0]      r_data,
  output logic                  r_last,
  input  logic                  r_ready,
  output logic                  busy,
  output logic                  done
`ifdef MANAGER_LOADER_TIMEOUT_EN
  , output logic                err
`endif
);

  localparam logic [WIDTH_ADDR-1:0] A_W    = WIDTH_ADDR'(addr_w_base());
  localparam logic [WIDTH_ADDR-1:0] A_I    = WIDTH_ADDR'(addr_i_base(LENGHT_I, LENGHT_MID, LENGHT_O));
  localparam logic [WIDTH_ADDR-1:0] A_S    = WIDTH_ADDR'(addr_start(LENGHT_I, LENGHT_MID, LENGHT_O));
  localparam logic [WIDTH_ADDR-1:0] A_O    = WIDTH_ADDR'(addr_o_base(LENGHT_I, LENGHT_MID, LENGHT_O));
  localparam logic [WIDTH_ADDR-1:0] LAST_W = WIDTH_ADDR'(N_W - 1);
  localparam logic [WIDTH_ADDR-1:0] LAST_I = WIDTH_ADDR'(LENGHT_I - 1);
  localparam logic [WIDTH_ADDR-1:0] LAST_O = WIDTH_ADDR'(LENGHT_O - 1);

  loader_state_t         state;
  logic [WIDTH_ADDR-1:0] idx;
  logic                  pending;
  logic                  req;
  logic                  rnw;
  logic [WIDTH_ADDR-1:0] addr;
  logic [WIDTH_W-1:0]    wdata;
  logic                  ack;
  logic [WIDTH-1:0]      rdata_q;
  logic                  abort;

  // Request/address selection for the bus engine
  always_comb begin
    req   = 1'b0;
    rnw   = 1'b0;
    addr  = '0;
    wdata = '0;
    case (state)
      ST_LOAD_W: begin
        req   = s_valid && s_ready;
        addr  = A_W + idx;
        wdata = s_data;
      end
      ST_LOAD_I: begin
        req   = s_valid && s_ready;
        addr  = A_I + idx;
        wdata = s_data;
      end
      ST_START: begin
        req   = !pending;
        addr  = A_S;
        wdata = WIDTH_W'(1);
      end
      ST_READ_O: begin
        req  = !pending;
        rnw  = 1'b1;
        addr = A_O + idx;
      end
      default: ;
    endcase
  end

  manager_bus_port #(
    .WIDTH     (WIDTH),
    .WIDTH_W   (WIDTH_W),
    .WIDTH_ADDR(WIDTH_ADDR)
  ) u_bus_port (
    .clk      (clk),
    .reset    (reset),
    .req      (req),
    .rnw      (rnw),
    .abort    (abort),
    .addr     (addr),
    .wdata    (wdata),
    .bus_wdata(bus_wdata),
    .bus_addr (bus_addr),
    .bus_read (bus_read),
    .bus_write(bus_write),
    .bus_rdata(bus_rdata),
    .bus_ready(bus_ready),
    .ack      (ack),
    .rdata_q  (rdata_q)
  );

`ifdef MANAGER_LOADER_TIMEOUT_EN
  localparam int unsigned TO_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;

  logic [TO_W-1:0] to_cnt;
  logic            waiting;

  assign waiting = ((bus_read | bus_write) && !bus_ready) || (state == ST_WAIT_DONE && !bus_down);
  assign abort   = waiting && (to_cnt == TO_W'(TIMEOUT - 1));

  // Wait-cycle counter and sticky error flag
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      to_cnt <= '0;
      err    <= 1'b0;
    end else begin
      if (state == ST_IDLE && start) err <= 1'b0;
      else if (abort)                err <= 1'b1;
      if (abort || !waiting) to_cnt <= '0;
      else                   to_cnt <= to_cnt + TO_W'(1);
    end
  end
`else
  assign abort = 1'b0;
`endif

  // Sequencer: load weights, load inputs, start, wait, read and emit results
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= ST_IDLE;
      idx     <= '0;
      pending <= 1'b0;
      s_ready <= 1'b0;
      r_valid <= 1'b0;
      r_data  <= '0;
      r_last  <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (abort) begin
        state   <= ST_IDLE;
        idx     <= '0;
        pending <= 1'b0;
        s_ready <= 1'b0;
        r_valid <= 1'b0;
        r_last  <= 1'b0;
        busy    <= 1'b0;
        done    <= 1'b1;
      end else begin
        case (state)
          ST_IDLE: begin
            if (start) begin
              state   <= ST_LOAD_W;
              busy    <= 1'b1;
              idx     <= '0;
              s_ready <= 1'b1;
            end
          end
          ST_LOAD_W: begin
            if (req) begin
              pending <= 1'b1;
              s_ready <= 1'b0;
            end else if (ack) begin
              pending <= 1'b0;
              s_ready <= 1'b1;
              if (idx == LAST_W) begin
                state <= ST_LOAD_I;
                idx   <= '0;
              end else begin
                idx <= idx + WIDTH_ADDR'(1);
              end
            end
          end
          ST_LOAD_I: begin
            if (req) begin
              pending <= 1'b1;
              s_ready <= 1'b0;
            end else if (ack) begin
              pending <= 1'b0;
              if (idx == LAST_I) begin
                state <= ST_START;
                idx   <= '0;
              end else begin
                s_ready <= 1'b1;
                idx     <= idx + WIDTH_ADDR'(1);
              end
            end
          end
          ST_START: begin
            if (req) begin
              pending <= 1'b1;
            end else if (ack) begin
              pending <= 1'b0;
              state   <= ST_WAIT_DONE;
            end
          end
          ST_WAIT_DONE: begin
            if (bus_down) begin
              state <= ST_READ_O;
              idx   <= '0;
            end
          end
          ST_READ_O: begin
            if (req) begin
              pending <= 1'b1;
            end else if (ack) begin
              pending <= 1'b0;
              state   <= ST_EMIT;
              r_valid <= 1'b1;
              r_data  <= rdata_q;
              r_last  <= (idx == LAST_O);
            end
          end
          ST_EMIT: begin
            if (r_ready) begin
              r_valid <= 1'b0;
              r_last  <= 1'b0;
              if (idx == LAST_O) begin
                state <= ST_IDLE;
                busy  <= 1'b0;
                done  <= 1'b1;
              end else begin
                idx   <= idx + WIDTH_ADDR'(1);
                state <= ST_READ_O;
              end
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule
